// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch: one-outstanding fetch FSM feeding a small FIFO toward decode.
// Optional macro FETCH_MISALIGN_CHK_EN flags misaligned redirect targets and stalls fetch.
module fetch_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_select_execute,
    input  logic [XLEN-1:0] pc_target_execute,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instruction_fetch,
    output logic [XLEN-1:0] pc_fetch,
    output logic [XLEN-1:0] next_pc_fetch,
    output logic            fetch_misalign
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RSP,
        DISCARD
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_fpc;
    logic [XLEN-1:0] r_req_pc;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [XLEN-1:0] r_qpc   [QDEPTH];
    logic [ILEN-1:0] r_qinstr[QDEPTH];

    logic [XLEN-1:0] w_target;
    logic            w_req_fire;
    logic            w_push;
    logic            w_pop;

`ifdef FETCH_MISALIGN_CHK_EN
    logic r_misalign;

    assign w_target = pc_target_execute;

    // Sticky until the next redirect re-evaluates the target alignment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_misalign <= 1'b0;
        else if (pc_select_execute)
            r_misalign <= (pc_target_execute[1:0] != 2'b00);
    end

    assign fetch_misalign = r_misalign;
`else
    assign w_target       = pc_target_execute & ~XLEN'(3);
    assign fetch_misalign = 1'b0;
`endif

    // Requests only from IDLE, so a free slot seen here stays reserved until the response.
    assign imem_req_valid = rst && (r_state == IDLE) && (r_count < DEPTH_C)
                            && !pc_select_execute && !fetch_misalign;
    assign imem_req_addr  = r_fpc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_push         = (r_state == WAIT_RSP) && imem_rsp_valid && !pc_select_execute;
    assign w_pop          = instr_valid && instr_ready && !pc_select_execute;

    assign instr_valid       = (r_count != '0);
    assign instruction_fetch = r_qinstr[r_rptr];
    assign pc_fetch          = r_qpc[r_rptr];
    assign next_pc_fetch     = pc_fetch + XLEN'(4);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_fpc    <= RESET_PC;
            r_req_pc <= RESET_PC;
            r_count  <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
        end else if (pc_select_execute) begin
            r_fpc   <= w_target;
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            // An in-flight response must be swallowed, whether it lands now or later.
            if (r_state != IDLE)
                r_state <= imem_rsp_valid ? IDLE : DISCARD;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_fire) begin
                        r_state  <= WAIT_RSP;
                        r_req_pc <= r_fpc;
                        r_fpc    <= r_fpc + XLEN'(4);
                    end
                end
                WAIT_RSP: if (imem_rsp_valid) r_state <= IDLE;
                DISCARD:  if (imem_rsp_valid) r_state <= IDLE;
                default:  r_state <= IDLE;
            endcase
            if (w_push)
                r_wptr <= r_wptr + PW'(1);
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_qpc[r_wptr]    <= r_req_pc;
            r_qinstr[r_wptr] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomized scoreboard bench for fetch_prefetch_queue with a program-order reference model.
// Covers the FETCH_MISALIGN_CHK_EN build when that macro is defined.
module tb_fetch_prefetch_queue;

    localparam int          XLEN     = 32;
    localparam int          ILEN     = 32;
    localparam int          QDEPTH   = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            pc_select_execute = 1'b0;
    logic [XLEN-1:0] pc_target_execute = '0;
    logic            imem_req_valid;
    logic            imem_req_ready = 1'b0;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid = 1'b0;
    logic [ILEN-1:0] imem_rsp_data = '0;
    logic            instr_valid;
    logic            instr_ready = 1'b0;
    logic [ILEN-1:0] instruction_fetch;
    logic [XLEN-1:0] pc_fetch;
    logic [XLEN-1:0] next_pc_fetch;
    logic            fetch_misalign;

    fetch_prefetch_queue #(
        .XLEN(XLEN), .ILEN(ILEN), .QDEPTH(QDEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst),
        .pc_select_execute(pc_select_execute), .pc_target_execute(pc_target_execute),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction_fetch(instruction_fetch), .pc_fetch(pc_fetch),
        .next_pc_fetch(next_pc_fetch), .fetch_misalign(fetch_misalign)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Memory model: one outstanding request, answered after a chosen delay.
    bit          memPending = 0;
    logic [31:0] memAddr = '0;
    int          memDelay = 0;
    int          latencyMin = 0;
    int          latencyMax = 0;
    int          rspCount = 0;
    bit          sampledHs = 0;
    logic [31:0] sampledAddr = '0;
    bit          sampledRsp = 0;
    bit          rstNext = 0;
    logic [31:0] hsLog[$];

    // Reference model: the program-order stream of fetched words.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;
    entry_t      expQ[$];
    logic [31:0] modelFpc = RESET_PC;
    bit          modelMis = 0;
    int          popCount = 0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // One clock cycle: drive after the rising edge, sample at the falling edge.
    task automatic applyStimulus(input bit instrRdy, input bit reqRdy, input bit redir, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        if (sampledRsp)
            memPending = 0;
        if (sampledHs) begin
            memPending = 1;
            memAddr    = sampledAddr;
            memDelay   = $urandom_range(latencyMax, latencyMin);
        end else if (memPending && memDelay > 0) begin
            memDelay--;
        end
        rst               = rstNext;
        imem_rsp_valid    = memPending && (memDelay == 0);
        imem_rsp_data     = imem_rsp_valid ? memWord(memAddr) : $urandom;
        instr_ready       = instrRdy;
        imem_req_ready    = reqRdy;
        pc_select_execute = redir;
        pc_target_execute = tgt;
        @(negedge clk);
        sampledHs   = imem_req_valid && imem_req_ready;
        sampledAddr = imem_req_addr;
        sampledRsp  = imem_rsp_valid;
        if (sampledRsp)
            rspCount++;
        if (sampledHs)
            hsLog.push_back(sampledAddr);
    endtask

    // Leaves reset asserted; the next applyStimulus call releases it.
    task automatic resetDut();
        rstNext = 0;
        repeat (5) applyStimulus(0, 0, 0, 32'h0);
        memPending = 0;
        sampledRsp = 0;
        sampledHs  = 0;
        rspCount   = 0;
        hsLog.delete();
        rstNext    = 1;
    endtask

    // Monitor: pops the scoreboard whenever decode accepts an instruction.
    initial begin
        entry_t head;
        forever begin
            @(negedge clk);
            if (!rst) begin
                checkOutput("resetReqValid", imem_req_valid, 0);
                checkOutput("resetInstrValid", instr_valid, 0);
                checkOutput("resetMisalign", fetch_misalign, 0);
                expQ.delete();
                modelFpc = RESET_PC;
                modelMis = 0;
            end else if (pc_select_execute) begin
                checkOutput("redirectReqValid", imem_req_valid, 0);
                expQ.delete();
`ifdef FETCH_MISALIGN_CHK_EN
                modelFpc = pc_target_execute;
                modelMis = (pc_target_execute % 4) != 0;
`else
                modelFpc = (pc_target_execute / 4) * 4;
`endif
            end else begin
                checkOutput("misalignFlag", fetch_misalign, modelMis);
                if (modelMis)
                    checkOutput("misalignStall", imem_req_valid, 0);
                if (imem_req_valid && imem_req_ready) begin
                    checkOutput("reqAddr", imem_req_addr, modelFpc);
                    checkOutput("reqRoom", expQ.size() < QDEPTH, 1);
                    expQ.push_back({modelFpc, memWord(modelFpc)});
                    modelFpc = modelFpc + 32'd4;
                end
                if (instr_valid && instr_ready) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL popEmpty: got pc 0x%08h expected no instruction", pc_fetch);
                    end else begin
                        head = expQ.pop_front();
                        checkOutput("popPc", pc_fetch, head.pc);
                        checkOutput("popInstr", instruction_fetch, head.data);
                        checkOutput("popNextPc", next_pc_fetch, head.pc + 32'd4);
                        popCount++;
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] tgt;
        bit          redir;

        // Reset release and first fetches with a ready, zero-latency memory.
        resetDut();
        latencyMin = 0;
        latencyMax = 0;
        applyStimulus(1, 1, 0, 32'h0);
        checkOutput("firstReqValid", imem_req_valid, 1);
        checkOutput("firstReqAddr", imem_req_addr, RESET_PC);
        applyStimulus(1, 1, 0, 32'h0);
        checkOutput("firstRspValid", imem_rsp_valid, 1);
        checkOutput("noInstrYet", instr_valid, 0);
        applyStimulus(1, 1, 0, 32'h0);
        checkOutput("firstInstrValid", instr_valid, 1);
        checkOutput("firstPc", pc_fetch, 32'h0);
        checkOutput("firstNextPc", next_pc_fetch, 32'h4);
        checkOutput("firstInstr", instruction_fetch, memWord(32'h0));
        repeat (8) applyStimulus(1, 1, 0, 32'h0);
        checkOutput("hsCount", hsLog.size() >= 3, 1);
        if (hsLog.size() >= 3) begin
            checkOutput("hsAddr0", hsLog[0], 32'h0);
            checkOutput("hsAddr1", hsLog[1], 32'h4);
            checkOutput("hsAddr2", hsLog[2], 32'h8);
        end

        // Decode stalled: queue fills to its depth and fetch stops.
        resetDut();
        repeat (20) applyStimulus(0, 1, 0, 32'h0);
        checkOutput("fullRspCount", rspCount, QDEPTH);
        checkOutput("fullReqValid", imem_req_valid, 0);
        checkOutput("fullInstrValid", instr_valid, 1);
        checkOutput("fullHeadPc", pc_fetch, 32'h0);
        repeat (12) applyStimulus(1, 1, 0, 32'h0);

        // Redirect while waiting; the late response is discarded.
        resetDut();
        latencyMin = 1;
        latencyMax = 1;
        applyStimulus(1, 1, 0, 32'h0);
        checkOutput("waitHs", sampledHs, 1);
        applyStimulus(1, 1, 1, 32'h40);
        checkOutput("waitNoRsp", imem_rsp_valid, 0);
        applyStimulus(1, 1, 0, 32'h0);
        checkOutput("discardRsp", imem_rsp_valid, 1);
        checkOutput("discardReqValid", imem_req_valid, 0);
        checkOutput("discardInstrValid", instr_valid, 0);
        applyStimulus(1, 1, 0, 32'h0);
        checkOutput("afterDiscardReqValid", imem_req_valid, 1);
        checkOutput("afterDiscardReqAddr", imem_req_addr, 32'h40);
        checkOutput("afterDiscardInstrValid", instr_valid, 0);

        // Redirect coinciding with the response.
        resetDut();
        latencyMin = 0;
        latencyMax = 0;
        applyStimulus(1, 1, 0, 32'h0);
        applyStimulus(1, 1, 1, 32'h100);
        checkOutput("coincideRsp", imem_rsp_valid, 1);
        applyStimulus(1, 1, 0, 32'h0);
        checkOutput("coincideInstrValid", instr_valid, 0);
        checkOutput("coincideReqValid", imem_req_valid, 1);
        checkOutput("coincideReqAddr", imem_req_addr, 32'h100);

        // Fetch PC wraps past the top of the address space.
        applyStimulus(1, 1, 1, 32'hFFFF_FFFC);
        applyStimulus(1, 1, 0, 32'h0);
        checkOutput("wrapReqAddr", imem_req_addr, 32'hFFFF_FFFC);
        applyStimulus(1, 1, 0, 32'h0);
        applyStimulus(1, 1, 0, 32'h0);
        checkOutput("wrapInstrValid", instr_valid, 1);
        checkOutput("wrapPc", pc_fetch, 32'hFFFF_FFFC);
        checkOutput("wrapNextPc", next_pc_fetch, 32'h0);
        checkOutput("wrapNextReqAddr", imem_req_addr, 32'h0);

        // Misaligned redirect target.
        applyStimulus(1, 1, 1, 32'h42);
        applyStimulus(1, 1, 0, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
        checkOutput("misFlagSet", fetch_misalign, 1);
        checkOutput("misNoReq", imem_req_valid, 0);
        repeat (3) applyStimulus(1, 1, 0, 32'h0);
        checkOutput("misStillNoReq", imem_req_valid, 0);
        applyStimulus(1, 1, 1, 32'h80);
        applyStimulus(1, 1, 0, 32'h0);
        checkOutput("misFlagClear", fetch_misalign, 0);
        checkOutput("misReqValid", imem_req_valid, 1);
        checkOutput("misReqAddr", imem_req_addr, 32'h80);
`else
        checkOutput("misFlagTied", fetch_misalign, 0);
        checkOutput("misMaskReqValid", imem_req_valid, 1);
        checkOutput("misMaskReqAddr", imem_req_addr, 32'h40);
`endif

        // Randomized traffic against the scoreboard.
        latencyMin = 0;
        latencyMax = 2;
        popCount   = 0;
        for (int i = 0; i < 3000; i++) begin
            redir = ($urandom_range(0, 99) < 4);
            tgt   = $urandom;
            if ($urandom_range(0, 3) != 0)
                tgt[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0)
                tgt = 32'hFFFF_FFF0;
            applyStimulus($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70, redir, tgt);
            if (i % 1000 == 999)
                resetDut();
        end
        repeat (20) applyStimulus(1, 1, 0, 32'h0);
        checks++;
        if (popCount < 200) begin
            errors++;
            $display("[TB] FAIL randomProgress: got %0d pops expected at least 200", popCount);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_queue.md
FETCH_PREFETCH_QUEUE -- requirements
Module: fetch_prefetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC and address width.
REQ-002 SHALL have parameter ILEN, default 32, meaning instruction word width.
REQ-003 SHALL have parameter QDEPTH, default 4, meaning instruction queue entries (power of two, >=2).
REQ-004 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-005 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port: rst  in  1  asynchronous active-low reset.
REQ-007 SHALL have port: pc_select_execute  in  1  redirect strobe from execute.
REQ-008 SHALL have port: pc_target_execute  in  XLEN  redirect target.
REQ-009 SHALL have ports: imem_req_valid out 1, imem_req_ready in 1, imem_req_addr out XLEN, meaning memory request handshake and byte address.
REQ-010 SHALL have ports: imem_rsp_valid in 1, imem_rsp_data in ILEN, meaning memory response.
REQ-011 SHALL have ports: instr_valid out 1, instr_ready in 1, meaning decode handshake.
REQ-012 SHALL have ports: instruction_fetch out ILEN, pc_fetch out XLEN, next_pc_fetch out XLEN, meaning queue-head instruction, its PC, and its PC+4.
REQ-013 SHALL have port: fetch_misalign  out  1  sticky misaligned-redirect flag.

Function
REQ-014 SHALL hold fetch PC fpc; fpc advances by 4 on each request handshake, wrapping modulo 2^XLEN.
REQ-015 SHALL implement FSM states IDLE, WAIT_RSP, DISCARD; one outstanding request maximum.
REQ-016 SHALL drive imem_req_valid = (state==IDLE) && (count<QDEPTH) && !pc_select_execute, with imem_req_addr = fpc.
REQ-017 SHALL transition IDLE->WAIT_RSP on imem_req_valid && imem_req_ready.
REQ-018 SHALL, in WAIT_RSP with imem_rsp_valid, push {fpc_of_request, imem_rsp_data} into the queue and return to IDLE; next request issues no earlier than the following cycle.
REQ-019 SHALL guarantee no queue overflow: a request is issued only when an entry is free, and the free entry stays reserved until its response.
REQ-020 SHALL drive instr_valid = (count!=0); instruction_fetch/pc_fetch show the head entry; pop on instr_valid && instr_ready.
REQ-021 SHALL hold head outputs stable while instr_valid && !instr_ready.
REQ-022 SHALL support push and pop in the same cycle, count unchanged.
REQ-023 SHALL compute next_pc_fetch = pc_fetch + 4 modulo 2^XLEN.
REQ-024 SHALL, on a cycle with pc_select_execute=1: empty the queue, load fpc <= pc_target_execute, ignore that cycle's pop and push.
REQ-025 SHALL, on redirect in WAIT_RSP without imem_rsp_valid, enter DISCARD; with imem_rsp_valid the response is dropped and state goes IDLE.
REQ-026 SHALL, in DISCARD, drop the next response and go IDLE; a further redirect in DISCARD updates fpc and stays in DISCARD.
REQ-027 SHALL give redirect priority over all other events.
REQ-028 SHALL give first instruction latency of 2 cycles from request handshake with zero-latency memory (response cycle + push).

Reset
REQ-029 SHALL, while rst=0, force: fpc=RESET_PC, state=IDLE, count=0, fetch_misalign=0, instr_valid=0, imem_req_valid=0.
REQ-030 SHALL drop any response arriving for a request issued before reset deassertion.
REQ-031 SHALL issue the first request at RESET_PC in the first cycle after rst rises.

Configuration
REQ-032 SHALL, with macro FETCH_MISALIGN_CHK_EN defined, set fetch_misalign on a redirect whose target[1:0]!=0, suppress requests while set, clear it on next aligned redirect or reset.
REQ-033 SHALL, without FETCH_MISALIGN_CHK_EN, tie fetch_misalign to 0 and force pc_target_execute[1:0] to 2'b00 when loading fpc.

Verification
REQ-034 SHALL cover: reset release, ready memory, instr_ready=1 -> requests at 0x0,0x4,0x8; pc_fetch 0x0 with next_pc_fetch 0x4 first.
REQ-035 SHALL cover: instr_ready=0 with QDEPTH=4 -> exactly 4 responses queued, imem_req_valid low, head stays pc 0x0.
REQ-036 SHALL cover: redirect to 0x40 while in WAIT_RSP, response next cycle -> response dropped, next request addr 0x40, queue empty meanwhile.
REQ-037 SHALL cover: redirect to 0x100 coinciding with response -> response dropped, state IDLE, next request 0x100.
REQ-038 SHALL cover: fpc=0xFFFF_FFFC fetch -> next request 0x0, next_pc_fetch=0x0.
REQ-039 SHALL cover: FETCH_MISALIGN_CHK_EN defined, redirect to 0x42 -> fetch_misalign=1, no requests; redirect to 0x80 -> flag clears, request 0x80.
